// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle for program_loader.
//   byte_valid_i / byte_data_i / byte_ready_o : valid/ready byte stream into the loader
//   Write_Enable_o / Write_Address_o / Write_Data_o : one-cycle write strobe toward instruction memory
// slave  : loader view (consumes bytes, produces writes)
// master : environment view (produces bytes, observes writes)
interface program_loader_if;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        Write_Enable_o;
   logic [31:0] Write_Address_o;
   logic [31:0] Write_Data_o;

   modport slave (
      input  byte_valid_i,
      input  byte_data_i,
      output byte_ready_o,
      output Write_Enable_o,
      output Write_Address_o,
      output Write_Data_o
   );

   modport master (
      output byte_valid_i,
      output byte_data_i,
      input  byte_ready_o,
      input  Write_Enable_o,
      input  Write_Address_o,
      input  Write_Data_o
   );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader.
// Receives a byte stream {count_lo, count_hi, 4*N payload bytes (little-endian words),
// xor checksum}, writes each assembled word to ADDR_BASE + 4*index and releases the
// core from reset only when the checksum matches.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   bus          program_loader_if.slave: byte stream in, memory write strobe out
//   load_i       restart request, honoured only in DONE or ERROR
//   core_hold_o  1 = core held in reset
//   done_o       load finished with matching checksum
//   error_o      load aborted (bad count or checksum mismatch)
//
// state   | meaning
// --------+-----------------------------------------------------
// HDR_LO  | waiting for word-count low byte
// HDR_HI  | waiting for word-count high byte, count validated here
// PAYLOAD | assembling words, one write strobe per 4th byte
// CHECK   | waiting for checksum byte
// DONE    | load good, core released, waits for load_i
// ERROR   | load bad, core held, waits for load_i
module program_loader #(
   parameter int          MEMORY_DEPTH = 64,
   parameter logic [31:0] ADDR_BASE    = 32'h0040_0000
) (
   input  logic                clk,
   input  logic                reset,
   program_loader_if.slave     bus,
   input  logic                load_i,
   output logic                core_hold_o,
   output logic                done_o,
   output logic                error_o
);

   localparam int          IDX_W   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
   localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

   typedef enum logic [2:0] {
      S_HDR_LO  = 3'd0,
      S_HDR_HI  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHECK   = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_byte_ready;
   logic               r_core_hold;
   logic               r_done;
   logic               r_error;
   logic               w_byte_ready_nxt;
   logic               w_core_hold_nxt;
   logic               w_done_nxt;
   logic               w_error_nxt;

   logic [15:0]        r_count;
   logic [IDX_W-1:0]   r_index;
   logic [1:0]         r_lane;
   logic [7:0]         r_csum;
   logic [23:0]        r_word;
   logic               r_we;
   logic [31:0]        r_waddr;
   logic [31:0]        r_wdata;

   logic               w_xfer;
   logic [15:0]        w_count_full;
   logic               w_count_bad;
   logic               w_last_lane;
   logic               w_last_word;

   assign w_xfer       = bus.byte_valid_i && r_byte_ready;
   assign w_count_full = {bus.byte_data_i, r_count[7:0]};
   assign w_count_bad  = (w_count_full == 16'd0) || (w_count_full > DEPTH16);
   assign w_last_lane  = (r_lane == 2'd3);
   assign w_last_word  = (16'(r_index) == (r_count - 16'd1));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_HDR_LO;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_HDR_LO: begin
            if (w_xfer) w_state_nxt = S_HDR_HI;
         end
         S_HDR_HI: begin
            if (w_xfer) w_state_nxt = w_count_bad ? S_ERROR : S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (w_xfer && w_last_lane && w_last_word) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (w_xfer) w_state_nxt = (bus.byte_data_i == r_csum) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: begin
            if (load_i) w_state_nxt = S_HDR_LO;
         end
         default: w_state_nxt = S_HDR_LO;
      endcase
   end

   // Status outputs are decoded from the next state and registered, so they
   // change on the same edge that moves the FSM.
   always_comb begin
      w_byte_ready_nxt = 1'b0;
      w_core_hold_nxt  = 1'b1;
      w_done_nxt       = 1'b0;
      w_error_nxt      = 1'b0;
      case (w_state_nxt)
         S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CHECK: w_byte_ready_nxt = 1'b1;
         S_DONE: begin
            w_core_hold_nxt = 1'b0;
            w_done_nxt      = 1'b1;
         end
         S_ERROR: w_error_nxt = 1'b1;
         default: w_byte_ready_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byte_ready <= 1'b0;
         r_core_hold  <= 1'b1;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_byte_ready <= w_byte_ready_nxt;
         r_core_hold  <= w_core_hold_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
      end
   end

   // Datapath: header capture, word assembly, checksum and write strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 16'd0;
         r_index <= '0;
         r_lane  <= 2'd0;
         r_csum  <= 8'd0;
         r_word  <= 24'd0;
         r_we    <= 1'b0;
         r_waddr <= ADDR_BASE;
         r_wdata <= 32'd0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_HDR_LO: begin
               if (w_xfer) r_count[7:0] <= bus.byte_data_i;
            end
            S_HDR_HI: begin
               if (w_xfer) begin
                  r_count[15:8] <= bus.byte_data_i;
                  r_index       <= '0;
                  r_lane        <= 2'd0;
                  r_csum        <= 8'd0;
               end
            end
            S_PAYLOAD: begin
               if (w_xfer) begin
                  r_csum <= r_csum ^ bus.byte_data_i;
                  r_lane <= r_lane + 2'd1;
                  case (r_lane)
                     2'd0: r_word[7:0]   <= bus.byte_data_i;
                     2'd1: r_word[15:8]  <= bus.byte_data_i;
                     2'd2: r_word[23:16] <= bus.byte_data_i;
                     default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {bus.byte_data_i, r_word};
                        r_waddr <= ADDR_BASE + (32'(r_index) << 2);
                        // index stops on the last word so it never passes MEMORY_DEPTH-1
                        if (!w_last_word) r_index <= r_index + 1'b1;
                     end
                  endcase
               end
            end
            S_DONE, S_ERROR: begin
               if (load_i) begin
                  r_count <= 16'd0;
                  r_index <= '0;
                  r_lane  <= 2'd0;
                  r_csum  <= 8'd0;
                  r_word  <= 24'd0;
               end
            end
            default: r_we <= 1'b0;
         endcase
      end
   end

   assign bus.byte_ready_o    = r_byte_ready;
   assign bus.Write_Enable_o  = r_we;
   assign bus.Write_Address_o = r_waddr;
   assign bus.Write_Data_o    = r_wdata;
   assign core_hold_o         = r_core_hold;
   assign done_o              = r_done;
   assign error_o             = r_error;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic load_i = 1'b0;
   logic core_hold_o, done_o, error_o;

   program_loader_if bus();

   program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .load_i      (load_i),
      .core_hold_o (core_hold_o),
      .done_o      (done_o),
      .error_o     (error_o)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_wr[$];
   logic [31:0] last_addr = BASE;
   logic [31:0] last_data = 32'd0;
   int          xfer_cnt  = 0;
   bit          prev_we   = 1'b0;
   bit          load_noise = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: runs just after each falling edge, once the driver has settled.
   always @(negedge clk) begin
      logic [63:0] e;
      #2;
      if (bus.byte_valid_i && bus.byte_ready_o) xfer_cnt++;
      if (bus.Write_Enable_o) begin
         chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
         if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=%h data=%h expected no write",
                     bus.Write_Address_o, bus.Write_Data_o);
         end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", bus.Write_Address_o, e[63:32]);
            chk("wr_data", bus.Write_Data_o, e[31:0]);
         end
      end
      prev_we = bus.Write_Enable_o;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard = 0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.byte_valid_i = 1'b0;
         if (load_noise) load_i = 1'($urandom_range(0, 1));
      end
      forever begin
         @(negedge clk);
         bus.byte_valid_i = 1'b1;
         bus.byte_data_i  = b;
         if (load_noise) load_i = 1'($urandom_range(0, 1));
         if (bus.byte_ready_o) begin
            @(posedge clk);
            break;
         end
         guard++;
         if (guard > 50) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=not_accepted expected=accepted byte=%h", b);
            break;
         end
      end
   endtask

   // Reference model: derive the whole expected outcome of a stream from its bytes.
   task automatic run_stream(input logic [7:0] q[$], input int gap, input bit hold_valid);
      int          n;
      bit          bad;
      bit          good;
      int          exp_acc;
      int          start;
      logic [7:0]  cs;
      logic [31:0] w;
      n   = int'(q[0]) + 256 * int'(q[1]);
      bad = (n == 0) || (n > DEPTH);
      cs  = 8'd0;
      good = 1'b0;
      if (bad) begin
         exp_acc = 2;
      end else begin
         exp_acc = 4 * n + 3;
         for (int i = 0; i < n; i++) begin
            w = {q[2+4*i+3], q[2+4*i+2], q[2+4*i+1], q[2+4*i]};
            cs = cs ^ q[2+4*i] ^ q[2+4*i+1] ^ q[2+4*i+2] ^ q[2+4*i+3];
            last_addr = BASE + 32'(4 * i);
            last_data = w;
            exp_wr.push_back({last_addr, w});
         end
         good = (q[4*n+2] == cs);
      end
      start = xfer_cnt;
      for (int i = 0; i < exp_acc; i++) send_byte(q[i], gap);
      @(negedge clk);
      load_i = 1'b0;
      bus.byte_valid_i = hold_valid;
      chk("done", {31'd0, done_o}, {31'd0, good});
      chk("error", {31'd0, error_o}, {31'd0, !good});
      chk("core_hold", {31'd0, core_hold_o}, {31'd0, !good});
      chk("ready_end", {31'd0, bus.byte_ready_o}, 32'd0);
      chk("we_end", {31'd0, bus.Write_Enable_o}, 32'd0);
      chk("writes_pending", exp_wr.size(), 32'd0);
      chk("addr_hold", bus.Write_Address_o, last_addr);
      chk("data_hold", bus.Write_Data_o, last_data);
      repeat (hold_valid ? 5 : 1) @(negedge clk);
      bus.byte_valid_i = 1'b0;
      #3;
      chk("bytes_accepted", xfer_cnt - start, exp_acc);
      exp_wr.delete();
   endtask

   task automatic restart();
      @(negedge clk);
      load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      chk("restart_done", {31'd0, done_o}, 32'd0);
      chk("restart_error", {31'd0, error_o}, 32'd0);
      chk("restart_hold", {31'd0, core_hold_o}, 32'd1);
      chk("restart_ready", {31'd0, bus.byte_ready_o}, 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, {31'd0, bus.byte_ready_o}, 32'd0);
      chk({tag, "_we"}, {31'd0, bus.Write_Enable_o}, 32'd0);
      chk({tag, "_addr"}, bus.Write_Address_o, BASE);
      chk({tag, "_data"}, bus.Write_Data_o, 32'd0);
      chk({tag, "_hold"}, {31'd0, core_hold_o}, 32'd1);
      chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
      chk({tag, "_error"}, {31'd0, error_o}, 32'd0);
   endtask

   initial begin
      logic [7:0] s1[$];
      logic [7:0] s4[$];
      logic [7:0] q[$];
      int         n;
      int         mode;
      logic [7:0] cs;
      logic [7:0] b;

      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'd0;
      s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
      s4 = s1;
      s4[10] = 8'h60;

      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_release", {31'd0, bus.byte_ready_o}, 32'd1);

      run_stream(s1, 0, 1'b0);
      restart();
      q = '{8'h00, 8'h00};
      run_stream(q, 0, 1'b0);
      restart();
      q = '{8'h41, 8'h00};
      run_stream(q, 0, 1'b0);
      restart();
      run_stream(s4, 0, 1'b0);
      restart();
      run_stream(s1, 3, 1'b1);
      restart();

      load_noise = 1'b1;
      for (int k = 0; k < 10; k++) begin
         mode = $urandom_range(0, 9);
         q.delete();
         if (mode == 0) begin
            q = '{8'h00, 8'h00};
         end else if (mode == 1) begin
            n = $urandom_range(DEPTH + 1, 600);
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
         end else begin
            n = (mode == 2) ? DEPTH : $urandom_range(1, 6);
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            cs = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
               b = 8'($urandom);
               cs = cs ^ b;
               q.push_back(b);
            end
            if (mode >= 8) cs = cs ^ 8'($urandom_range(1, 255));
            q.push_back(cs);
         end
         run_stream(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         restart();
      end
      load_noise = 1'b0;

      // Abort a load after 5 bytes; no write may appear.
      for (int i = 0; i < 5; i++) send_byte(s1[i], 0);
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_values("midrst");
      repeat (3) @(negedge clk);
      check_reset_values("midrst_hold");
      last_addr = BASE;
      last_data = 32'd0;
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_midrst", {31'd0, bus.byte_ready_o}, 32'd1);
      run_stream(s1, 0, 1'b0);
      restart();
      run_stream(s1, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
